// File: rtl/lsd_pkg.sv
// Shared constants and state encoding for the loop stream detector and its replay buffer.
package lsd_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_DEPTH = 16;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IDLE,
    DETECT,
    CAPTURE,
    CONFIRM,
    STREAM
  } state_e;

endpackage

// File: rtl/loop_buffer_ram.sv
// Loop body storage: DEPTH x 32 register array, synchronous write, asynchronous read.
module loop_buffer_ram import lsd_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset; every entry is written in CAPTURE before CONFIRM or STREAM can read it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/loop_stream_buffer.sv
// Loop stream detector: finds a backward branch, captures and confirms the loop body,
// then stalls fetch and replays the body from the buffer until EX reports a mispredict.
module loop_stream_buffer import lsd_pkg::*; #(
  parameter int XLEN     = DEF_XLEN,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int MIN_ITER = 2,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            stall_in,
  input  logic [XLEN-1:0] curr_PC,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] immediate,
  input  logic            mispredict,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            block_signal,
  output logic            reuse_signal,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            flush,
  output logic [XLEN-1:0] new_pc
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   start_pc_q, start_pc_d;
  logic [XLEN-1:0]   end_pc_q, end_pc_d;
  logic [PTR_W-1:0]  len_m1_q, len_m1_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]        iter_q, iter_d;
  logic              flush_q, flush_d;
  logic [XLEN-1:0]   new_pc_q, new_pc_d;

  logic              accept, is_bwd, fits;
  logic [XLEN-1:0]   neg_imm, off, wr_pc, rd_pc;
  logic              ram_we;
  logic [PTR_W-1:0]  ram_waddr;
  logic [31:0]       ram_rdata;

  assign accept  = valid_in & ~stall_in;
  assign is_bwd  = ((instruction[6:0] == OPC_JAL) || (instruction[6:0] == OPC_BRANCH))
                   && immediate[XLEN-1];
  assign neg_imm = -immediate;
  assign off     = neg_imm >> 2;   // loop length minus one
  assign fits    = off < XLEN'(DEPTH);
  assign wr_pc   = start_pc_q + (XLEN'(wr_ptr_q) << 2);
  assign rd_pc   = start_pc_q + (XLEN'(rd_ptr_q) << 2);

  loop_buffer_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (instruction),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    start_pc_d = start_pc_q;
    end_pc_d   = end_pc_q;
    len_m1_d   = len_m1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    iter_d     = iter_q;
    flush_d    = 1'b0;
    new_pc_d   = '0;
    ram_we     = 1'b0;
    ram_waddr  = wr_ptr_q;

    if (mispredict) begin
      state_d  = IDLE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      iter_d   = '0;
      if (state_q == STREAM) begin
        flush_d  = 1'b1;
        new_pc_d = redirect_pc;
      end
    end else begin
      case (state_q)
        IDLE: if (accept && is_bwd && fits) begin
          start_pc_d = curr_PC + immediate;
          end_pc_d   = curr_PC;
          len_m1_d   = off[PTR_W-1:0];
          state_d    = DETECT;
        end
        DETECT: if (accept) begin
          if (curr_PC == start_pc_q) begin
            ram_we    = 1'b1;
            ram_waddr = '0;
            wr_ptr_d  = PTR_W'(1);
            state_d   = CAPTURE;
          end else begin
            state_d = IDLE;
          end
        end
        CAPTURE: if (accept) begin
          if (curr_PC == wr_pc) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (curr_PC == end_pc_q) begin
              iter_d   = 4'd1;
              rd_ptr_d = '0;
              state_d  = (MIN_ITER == 1) ? STREAM : CONFIRM;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CONFIRM: if (accept) begin
          if ((curr_PC == rd_pc) && (instruction == ram_rdata)) begin
            if (rd_ptr_q == len_m1_q) begin
              rd_ptr_d = '0;
              iter_d   = iter_q + 4'd1;
              if (iter_q + 4'd1 == 4'(MIN_ITER)) state_d = STREAM;
            end else begin
              rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
          end else begin
            state_d = IDLE;
          end
        end
        STREAM: if (!stall_in) begin
          rd_ptr_d = (rd_ptr_q == len_m1_q) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      start_pc_q <= '0;
      end_pc_q   <= '0;
      len_m1_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      iter_q     <= '0;
      flush_q    <= 1'b0;
      new_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      start_pc_q <= start_pc_d;
      end_pc_q   <= end_pc_d;
      len_m1_q   <= len_m1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      iter_q     <= iter_d;
      flush_q    <= flush_d;
      new_pc_q   <= new_pc_d;
    end
  end

  assign block_signal = (state_q == STREAM);
  assign reuse_signal = (state_q == STREAM);
  assign instr_out    = (state_q == STREAM) ? ram_rdata : '0;
  assign pc_out       = (state_q == STREAM) ? rd_pc : '0;
  assign flush        = flush_q;
  assign new_pc       = new_pc_q;

endmodule

// File: tb/tb_loop_stream_buffer.sv
// Directed bench for loop_stream_buffer: MIN_ITER=2 main instance plus a MIN_ITER=1 instance on the same stimulus.
module tb_loop_stream_buffer;

  logic        clk = 1'b0;
  logic        reset, valid_in, stall_in, mispredict;
  logic [31:0] curr_PC, instruction, immediate, redirect_pc;

  logic        block_signal, reuse_signal, flush;
  logic [31:0] instr_out, pc_out, new_pc;
  logic        block_1, reuse_1, flush_1;
  logic [31:0] instr_1, pc_1, new_pc_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  loop_stream_buffer #(.XLEN(32), .DEPTH(16), .MIN_ITER(2)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall_in(stall_in),
    .curr_PC(curr_PC), .instruction(instruction), .immediate(immediate),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .block_signal(block_signal), .reuse_signal(reuse_signal),
    .instr_out(instr_out), .pc_out(pc_out), .flush(flush), .new_pc(new_pc)
  );

  loop_stream_buffer #(.XLEN(32), .DEPTH(16), .MIN_ITER(1)) dut1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall_in(stall_in),
    .curr_PC(curr_PC), .instruction(instruction), .immediate(immediate),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .block_signal(block_1), .reuse_signal(reuse_1),
    .instr_out(instr_1), .pc_out(pc_1), .flush(flush_1), .new_pc(new_pc_1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] body_word(input logic [31:0] pc);
    return 32'h0000_0013 | (pc << 12);
  endfunction

  function automatic logic [31:0] br_word(input bit jal);
    return jal ? 32'h0000_006F : 32'h0000_0063;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm);
    valid_in    = 1'b1;
    stall_in    = 1'b0;
    curr_PC     = pc;
    instruction = instr;
    immediate   = imm;
    step();
  endtask

  task automatic idle_inputs();
    valid_in    = 1'b0;
    curr_PC     = '0;
    instruction = '0;
    immediate   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Backward branch at the loop end, then `passes` trips through the body ending on that branch.
  task automatic run_loop(input logic [31:0] start, input int n, input bit jal, input int passes);
    logic [31:0] end_pc;
    logic [31:0] imm;
    end_pc = start + 32'(4 * (n - 1));
    imm    = -32'(4 * (n - 1));
    feed(end_pc, br_word(jal), imm);
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < n; i++) begin
        if (i == n - 1) feed(end_pc, br_word(jal), imm);
        else            feed(start + 32'(4 * i), body_word(start + 32'(4 * i)), '0);
      end
    end
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_block"}, 32'(block_signal), 32'd0);
    check({tag, "_reuse"}, 32'(reuse_signal), 32'd0);
    check({tag, "_flush"}, 32'(flush), 32'd0);
    check({tag, "_newpc"}, new_pc, 32'd0);
    check({tag, "_pc"}, pc_out, 32'd0);
    check({tag, "_instr"}, instr_out, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    stall_in    = 1'b0;
    mispredict  = 1'b0;
    redirect_pc = '0;
    idle_inputs();
    step();
    do_reset();
    check_all_zero("reset");

    // Nine-instruction JAL loop 0x00..0x20, confirmed on the second pass.
    run_loop(32'h00, 9, 1'b1, 2);
    check("t1_block", 32'(block_signal), 32'd1);
    check("t1_reuse", 32'(reuse_signal), 32'd1);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t1_pc%0d", i), pc_out, 32'(4 * i));
      check($sformatf("t1_instr%0d", i), instr_out,
            (i == 8) ? br_word(1'b1) : body_word(32'(4 * i)));
      step();
    end
    check("t1_wrap_pc", pc_out, 32'h00);
    check("t1_wrap_instr", instr_out, body_word(32'h00));
    step();
    step();
    check("t4_pre_pc", pc_out, 32'h08);

    // Three stalled cycles hold the replay slot.
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4_hold_pc%0d", i), pc_out, 32'h08);
      check($sformatf("t4_hold_instr%0d", i), instr_out, body_word(32'h08));
    end
    stall_in = 1'b0;
    step();
    check("t4_adv_pc", pc_out, 32'h0C);

    // Loop exit from pc_out=0x0C.
    mispredict  = 1'b1;
    redirect_pc = 32'h24;
    step();
    mispredict  = 1'b0;
    check("t3_flush", 32'(flush), 32'd1);
    check("t3_newpc", new_pc, 32'h24);
    check("t3_block", 32'(block_signal), 32'd0);
    check("t3_reuse", 32'(reuse_signal), 32'd0);
    check("t3_pc", pc_out, 32'd0);
    step();
    check("t3_flush_after", 32'(flush), 32'd0);
    check("t3_newpc_after", new_pc, 32'd0);

    // Forward JAL and a 21-instruction loop are both ignored.
    do_reset();
    feed(32'h40, br_word(1'b1), 32'd16);
    idle_inputs();
    check("t2_fwd_block", 32'(block_signal), 32'd0);
    run_loop(32'hB0, 21, 1'b0, 2);
    check("t2_long_block", 32'(block_signal), 32'd0);
    check("t2_long_flush", 32'(flush), 32'd0);

    // Exactly DEPTH instructions is the longest loop that streams.
    run_loop(32'h100, 16, 1'b0, 2);
    check("t2_full_block", 32'(block_signal), 32'd1);
    check("t2_full_pc0", pc_out, 32'h100);
    for (int i = 0; i < 15; i++) step();
    check("t2_full_pc15", pc_out, 32'h13C);
    check("t2_full_instr15", instr_out, br_word(1'b0));
    step();
    check("t2_full_wrap", pc_out, 32'h100);

    // Non-contiguous PC during capture abandons the loop.
    do_reset();
    feed(32'h20, br_word(1'b1), -32'd32);
    feed(32'h00, body_word(32'h00), '0);
    feed(32'h04, body_word(32'h04), '0);
    feed(32'h08, body_word(32'h08), '0);
    feed(32'h14, body_word(32'h14), '0);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 9; i++) feed(32'(4 * i), body_word(32'(4 * i)), '0);
    idle_inputs();
    check("t5_block", 32'(block_signal), 32'd0);

    // Reset mid-capture, then mid-stream.
    do_reset();
    feed(32'h20, br_word(1'b1), -32'd32);
    feed(32'h00, body_word(32'h00), '0);
    feed(32'h04, body_word(32'h04), '0);
    do_reset();
    check_all_zero("t6_cap");
    run_loop(32'h00, 9, 1'b1, 2);
    check("t6_restream", 32'(block_signal), 32'd1);
    step();
    step();
    check("t6_stream_pc", pc_out, 32'h08);
    do_reset();
    check_all_zero("t6_str");
    step();
    check("t6_str_flush_later", 32'(flush), 32'd0);
    check("t6_str_block_later", 32'(block_signal), 32'd0);

    // MIN_ITER=1 streams straight after capture; MIN_ITER=2 is still confirming.
    do_reset();
    run_loop(32'h00, 9, 1'b1, 1);
    check("t6m_main_block", 32'(block_signal), 32'd0);
    check("t6m_block", 32'(block_1), 32'd1);
    check("t6m_reuse", 32'(reuse_1), 32'd1);
    check("t6m_pc0", pc_1, 32'h00);
    check("t6m_instr0", instr_1, body_word(32'h00));
    step();
    check("t6m_pc1", pc_1, 32'h04);
    mispredict  = 1'b1;
    redirect_pc = 32'h80;
    step();
    mispredict  = 1'b0;
    check("t6m_main_noflush", 32'(flush), 32'd0);
    check("t6m_flush", 32'(flush_1), 32'd1);
    check("t6m_newpc", new_pc_1, 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/loop_stream_buffer.md
Name: loop_stream_buffer

Overview:
Parametrised loop stream detector with an instruction replay buffer, placed between IF and IFID.
- Detects backward JAL and conditional branches, captures the loop body and confirms it over MIN_ITER iterations.
- Then stalls fetch and streams the body from the buffer until EX reports a mispredict.
- Generalises the single-mode JAL-only detector: handles conditional branches, configurable depth/width, confirmation count and downstream stall.

Parameters:
XLEN, 32, PC / immediate width
DEPTH, 16, max loop body length in instructions (power of two)
MIN_ITER, 2, completed iterations (including capture) required before streaming; legal range 1..15
PTR_W, $clog2(DEPTH), buffer pointer width (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
valid_in  in  1  IFID holds a valid instruction
stall_in  in  1  pipeline stalled; current IFID contents not consumed
curr_PC  in  XLEN  PC of IFID instruction
instruction  in  32  IFID instruction
immediate  in  XLEN  sign-extended branch/JAL offset from decode
mispredict  in  1  EX: loop exit or wrong-path
redirect_pc  in  XLEN  correct PC on mispredict
block_signal  out  1  stall front-end fetch
reuse_signal  out  1  IFID sourced from instr_out/pc_out
instr_out  out  32  replayed instruction
pc_out  out  XLEN  PC of replayed instruction
flush  out  1  one-cycle flush pulse
new_pc  out  XLEN  redirect target; valid only when flush=1, else 0

Behaviour:
- Accept: valid_in=1 and stall_in=0. Nothing advances without accept, except mispredict and reset.
- Backward branch: opcode [6:0] is 1101111 (JAL) or 1100011 (BRANCH), and immediate[XLEN-1]=1.
- Loop length: len = (-immediate>>2)+1.
- IDLE: on accepted backward branch with len<=DEPTH:
  - latch start_pc=curr_PC+immediate, end_pc=curr_PC, len; go to DETECT.
  - If len>DEPTH or immediate==0: stay IDLE.
- DETECT:
  - Accepted curr_PC==start_pc: write buf[0], wr_ptr=1, go to CAPTURE.
  - Any other accepted PC: go to IDLE.
- CAPTURE:
  - Accepted PC must equal start_pc+4*wr_ptr; write buf[wr_ptr] and increment wr_ptr. Mismatch: go to IDLE.
  - At end_pc: iter_cnt=1. Go to STREAM if MIN_ITER==1, else CONFIRM with rd_ptr=0.
- CONFIRM:
  - Each accepted instruction and PC must match buf[rd_ptr] and start_pc+4*rd_ptr. Mismatch: go to IDLE.
  - At index len-1: iter_cnt++ and rd_ptr=0. When iter_cnt reaches MIN_ITER, go to STREAM.
- STREAM:
  - block_signal=1, reuse_signal=1.
  - instr_out=buf[rd_ptr], pc_out=start_pc+4*rd_ptr, with combinational read of the registered array.
  - rd_ptr advances when stall_in=0 and wraps len-1 -> 0 (predict taken).
  - stall_in=1 holds all outputs.
- Mispredict:
  - In STREAM: flush=1 and new_pc=redirect_pc for exactly the next cycle; state goes to IDLE. block_signal/reuse_signal are 0 in that flush cycle.
  - Has priority over stall_in and over any same-cycle detect.
  - Outside STREAM: go to IDLE, flush stays 0.
- Reset (any state, including mid-stream):
  - Next edge: state IDLE; block_signal, reuse_signal, flush, new_pc, instr_out, pc_out, pointers and iter_cnt all 0.
  - No flush is generated. Buffer contents are not reset.
- Outputs in non-STREAM states: instr_out=0, pc_out=0.
- Arithmetic: all PC arithmetic is modulo 2^XLEN. Pointers are PTR_W bits with wrap via compare to len-1, not natural overflow.

Decomposition:
- Package lsd_pkg holds:
  - OPC_JAL=7'b1101111, OPC_BRANCH=7'b1100011
  - state encoding IDLE/DETECT/CAPTURE/CONFIRM/STREAM
  - default XLEN/DEPTH.
- Sub-module loop_buffer_ram: DEPTH x 32 register array, one sync write port, one async read port.
- FSM, PC compare and pointer logic stay in the top module.

Test Plan:
1. DEPTH=16, MIN_ITER=2: JAL at 0x20 with imm=-32. Feed 0x00..0x20 twice -> next cycle block_signal=1, reuse_signal=1, pc_out 0x00,0x04..0x20, then 0x00 (wrap); instr_out matches captured words.
2. JAL imm=+16; then BRANCH imm=-80 (len=21>16) -> state stays IDLE, block_signal=0 throughout.
3. STREAM at pc_out=0x0C with mispredict=1 and redirect_pc=0x24 -> next cycle flush=1, new_pc=0x24, block_signal=0; following cycle flush=0, new_pc=0.
4. STREAM with stall_in=1 for 3 cycles at pc_out=0x08 -> pc_out/instr_out held 3 cycles, then advance to 0x0C.
5. CAPTURE with PC jump 0x08->0x14 -> IDLE; feeding a full body afterwards does not stream without a new backward branch.
6. reset=1 for one cycle mid-CAPTURE and again mid-STREAM -> next edge all outputs 0, flush never asserted; MIN_ITER=1 variant streams right after the first capture.
